// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, protection bit positions,
// bus widths, channel state types and the access-permission helper.
package axi4_lite_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int PROT_PRIV_BIT   = 0;
    localparam int PROT_NONSEC_BIT = 1;
    localparam int PROT_INSTR_BIT  = 2;

    // Write channel: a reset holding state, idle, one half captured, response pending
    typedef enum logic [2:0] {
        WR_RESET,
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_RESP
    } wr_state_e;

    // Read channel: a reset holding state, idle, response pending
    typedef enum logic [1:0] {
        RD_RESET,
        RD_IDLE,
        RD_RESP
    } rd_state_e;

    // Decode errors win over protection errors; everything else is OKAY
    function automatic logic [1:0] accessResp(input logic       inRange,
                                              input logic [2:0] prot,
                                              input logic       protCheck);
        logic [1:0] resp;
        resp = RESP_OKAY;
        if (!inRange) begin
            resp = RESP_DECERR;
        end else if (protCheck && !prot[PROT_PRIV_BIT]) begin
            resp = RESP_SLVERR;
        end
        return resp;
    endfunction

endpackage

// File: rtl/axi4_lite_byte_ram.sv
// DEPTH x 32 storage with a byte-enabled synchronous write port and a
// synchronous read port that returns the contents from before a same-edge write.
// The array is deliberately not reset.
module axi4_lite_byte_ram
    import axi4_lite_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  wrEn_i,
    input  logic [IDX_W-1:0]      wrIdx_i,
    input  logic [AXI_STRB_W-1:0] wrStrb_i,
    input  logic [AXI_DATA_W-1:0] wrData_i,
    input  logic                  rdEn_i,
    input  logic [IDX_W-1:0]      rdIdx_i,
    output logic [AXI_DATA_W-1:0] rdData_o
);

    logic [AXI_DATA_W-1:0] mem_q [DEPTH];
    logic [AXI_DATA_W-1:0] rdData_q;

    // Byte-lane writes and registered reads; non-blocking updates give read-before-write
    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            for (int b = 0; b < AXI_STRB_W; b++) begin
                if (wrStrb_i[b]) begin
                    mem_q[wrIdx_i][b*8 +: 8] <= wrData_i[b*8 +: 8];
                end
            end
        end
        if (rdEn_i) begin
            rdData_q <= mem_q[rdIdx_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/axi4_lite_slave_memory.sv
// AXI4-Lite responder in front of a byte-writable word array. One write and
// one read may be outstanding at a time; the two channels run independently.
module axi4_lite_slave_memory
    import axi4_lite_pkg::*;
#(
    parameter int                    DEPTH      = 256,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = 32'h0000_0000,
    parameter bit                    PROT_CHECK = 1'b0
) (
    input  logic                  axi_clk,
    input  logic                  resetn,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [AXI_ADDR_W-1:0] axi_awaddr,
    input  logic [2:0]            axi_awprot,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    input  logic [AXI_DATA_W-1:0] axi_wdata,
    input  logic [AXI_STRB_W-1:0] axi_wstrb,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    output logic [1:0]            axi_bresp,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    input  logic [AXI_ADDR_W-1:0] axi_araddr,
    input  logic [2:0]            axi_arprot,
    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    output logic [AXI_DATA_W-1:0] axi_rdata,
    output logic [1:0]            axi_rresp
);

    localparam int                    IDX_W = $clog2(DEPTH);
    localparam logic [AXI_ADDR_W-1:0] SPAN  = AXI_ADDR_W'(DEPTH * 4);

    wr_state_e wrState_q, wrState_d;
    rd_state_e rdState_q, rdState_d;

    logic [AXI_ADDR_W-1:0] awAddr_q;
    logic [2:0]            awProt_q;
    logic [AXI_DATA_W-1:0] wData_q;
    logic [AXI_STRB_W-1:0] wStrb_q;
    logic [1:0]            bresp_q;
    logic [1:0]            rresp_q;

    logic awHs, wHs, bHs, arHs, rHs;
    logic commit;

    logic [AXI_ADDR_W-1:0] wrAddr, wrOffset, rdOffset;
    logic [2:0]            wrProt;
    logic [AXI_DATA_W-1:0] wrData, ramRdData;
    logic [AXI_STRB_W-1:0] wrStrb;
    logic [1:0]            wrResp, rdResp;

    // Channel readies and valids come straight from the channel states
    assign axi_awready = (wrState_q == WR_IDLE) || (wrState_q == WR_HAVE_W);
    assign axi_wready  = (wrState_q == WR_IDLE) || (wrState_q == WR_HAVE_AW);
    assign axi_bvalid  = (wrState_q == WR_RESP);
    assign axi_arready = (rdState_q == RD_IDLE);
    assign axi_rvalid  = (rdState_q == RD_RESP);

    assign awHs = axi_awvalid && axi_awready;
    assign wHs  = axi_wvalid  && axi_wready;
    assign bHs  = axi_bvalid  && axi_bready;
    assign arHs = axi_arvalid && axi_arready;
    assign rHs  = axi_rvalid  && axi_rready;

    // On the commit edge a half arriving this edge is taken from the bus, the other from its capture
    assign wrAddr   = awHs ? axi_awaddr : awAddr_q;
    assign wrProt   = awHs ? axi_awprot : awProt_q;
    assign wrData   = wHs  ? axi_wdata  : wData_q;
    assign wrStrb   = wHs  ? axi_wstrb  : wStrb_q;
    assign wrOffset = wrAddr - BASE_ADDR;
    assign wrResp   = accessResp(wrOffset < SPAN, wrProt, PROT_CHECK);

    assign rdOffset = axi_araddr - BASE_ADDR;
    assign rdResp   = accessResp(rdOffset < SPAN, axi_arprot, PROT_CHECK);

    // Write channel next state; commit fires when the second of AW/W is accepted
    always_comb begin
        wrState_d = wrState_q;
        commit    = 1'b0;
        case (wrState_q)
            WR_RESET: wrState_d = WR_IDLE;
            WR_IDLE: begin
                if (awHs && wHs) begin
                    commit    = 1'b1;
                    wrState_d = WR_RESP;
                end else if (awHs) begin
                    wrState_d = WR_HAVE_AW;
                end else if (wHs) begin
                    wrState_d = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: begin
                if (wHs) begin
                    commit    = 1'b1;
                    wrState_d = WR_RESP;
                end
            end
            WR_HAVE_W: begin
                if (awHs) begin
                    commit    = 1'b1;
                    wrState_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bHs) begin
                    wrState_d = WR_IDLE;
                end
            end
            default: wrState_d = WR_RESET;
        endcase
    end

    // Read channel next state; one accepted address per response
    always_comb begin
        rdState_d = rdState_q;
        case (rdState_q)
            RD_RESET: rdState_d = RD_IDLE;
            RD_IDLE: begin
                if (arHs) begin
                    rdState_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (rHs) begin
                    rdState_d = RD_IDLE;
                end
            end
            default: rdState_d = RD_RESET;
        endcase
    end

    // Channel state registers; reset parks both channels with all readies low
    always_ff @(posedge axi_clk or negedge resetn) begin
        if (!resetn) begin
            wrState_q <= WR_RESET;
            rdState_q <= RD_RESET;
        end else begin
            wrState_q <= wrState_d;
            rdState_q <= rdState_d;
        end
    end

    // Capture of the write halves and of the response codes
    always_ff @(posedge axi_clk or negedge resetn) begin
        if (!resetn) begin
            awAddr_q <= '0;
            awProt_q <= '0;
            wData_q  <= '0;
            wStrb_q  <= '0;
            bresp_q  <= RESP_OKAY;
            rresp_q  <= RESP_OKAY;
        end else begin
            if (awHs) begin
                awAddr_q <= axi_awaddr;
                awProt_q <= axi_awprot;
            end
            if (wHs) begin
                wData_q <= axi_wdata;
                wStrb_q <= axi_wstrb;
            end
            if (commit) begin
                bresp_q <= wrResp;
            end
            if (arHs) begin
                rresp_q <= rdResp;
            end
        end
    end

    axi4_lite_byte_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk_i   (axi_clk),
        .wrEn_i  (commit && (wrResp == RESP_OKAY)),
        .wrIdx_i (wrOffset[IDX_W+1:2]),
        .wrStrb_i(wrStrb),
        .wrData_i(wrData),
        .rdEn_i  (arHs && (rdResp == RESP_OKAY)),
        .rdIdx_i (rdOffset[IDX_W+1:2]),
        .rdData_o(ramRdData)
    );

    // Error responses and idle/reset periods present zero read data
    assign axi_rdata = (axi_rvalid && (rresp_q == RESP_OKAY)) ? ramRdData : '0;
    assign axi_bresp = bresp_q;
    assign axi_rresp = rresp_q;

endmodule
